// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, bubble insertion and illegal-op flagging
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              RegWrite_in,
  input  logic              RegDst_in,
  input  logic              ALUSrc_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemtoReg_in,
  input  logic [1:0]        ALUOp_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic [DATA_W-1:0] imm_ext_in,
  input  logic [4:0]        rs_addr_in,
  input  logic [4:0]        rt_addr_in,
  input  logic [4:0]        rd_addr_in,
  input  logic [5:0]        funct_in,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              RegWrite_ex,
  output logic              ALUSrc_ex,
  output logic              MemWrite_ex,
  output logic              MemRead_ex,
  output logic              MemtoReg_ex,
  output logic [1:0]        ALUOp_ex,
  output logic [DATA_W-1:0] rs_data_ex,
  output logic [DATA_W-1:0] rt_data_ex,
  output logic [DATA_W-1:0] imm_ext_ex,
  output logic [4:0]        rs_addr_ex,
  output logic [5:0]        funct_ex,
  output logic [4:0]        write_reg_ex,
  output logic              ex_valid,
  output logic              stall_id,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  logic              reg_write_q,  reg_write_d;
  logic              alu_src_q,    alu_src_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [1:0]        alu_op_q,     alu_op_d;
  logic [DATA_W-1:0] rs_data_q,    rs_data_d;
  logic [DATA_W-1:0] rt_data_q,    rt_data_d;
  logic [DATA_W-1:0] imm_ext_q,    imm_ext_d;
  logic [4:0]        rs_addr_q,    rs_addr_d;
  logic [5:0]        funct_q,      funct_d;
  logic [4:0]        write_reg_q,  write_reg_d;
  logic              ex_valid_q,   ex_valid_d;
  logic              illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic uses_rt;
  logic hazard;
  logic hold;

  // Load-use hazard and backpressure detection, seen by upstream in the same cycle
  always_comb begin
    uses_rt  = ~ALUSrc_in | MemWrite_in;
    hazard   = id_valid & ex_valid_q & mem_read_q & (write_reg_q != 5'd0) &
               ((write_reg_q == rs_addr_in) | (uses_rt & (write_reg_q == rt_addr_in)));
    hold     = ex_valid_q & ~ex_ready;
    stall_id = hold | hazard;
  end

  // Next-state selection with priority flush > hold > hazard > capture
  always_comb begin
    reg_write_d  = reg_write_q;
    alu_src_d    = alu_src_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_op_d     = alu_op_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_ext_d    = imm_ext_q;
    rs_addr_d    = rs_addr_q;
    funct_d      = funct_q;
    write_reg_d  = write_reg_q;
    ex_valid_d   = ex_valid_q;
    illegal_op_d = 1'b0;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      // Kill whatever sits in EX, even if EX is stalled
      ex_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (hold) begin
      // EX not consuming: keep everything
    end else if (hazard) begin
      ex_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (id_valid && (ALUOp_in != ALUOP_ILLEGAL)) begin
      reg_write_d  = RegWrite_in;
      alu_src_d    = ALUSrc_in;
      mem_write_d  = MemWrite_in;
      mem_read_d   = MemRead_in;
      mem_to_reg_d = MemtoReg_in;
      alu_op_d     = ALUOp_in;
      rs_data_d    = rs_data_in;
      rt_data_d    = rt_data_in;
      imm_ext_d    = imm_ext_in;
      rs_addr_d    = rs_addr_in;
      funct_d      = funct_in;
      write_reg_d  = RegDst_in ? rd_addr_in : rt_addr_in;
      ex_valid_d   = 1'b1;
    end else begin
      // Empty slot or illegal opcode: insert a bubble, flag illegal ones
      ex_valid_d   = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      illegal_op_d = id_valid;
    end
  end

  // Pipeline register state with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= 2'b00;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      rs_addr_q    <= 5'd0;
      funct_q      <= 6'd0;
      write_reg_q  <= 5'd0;
      ex_valid_q   <= 1'b0;
      illegal_op_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      alu_src_q    <= alu_src_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_op_q     <= alu_op_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_ext_q    <= imm_ext_d;
      rs_addr_q    <= rs_addr_d;
      funct_q      <= funct_d;
      write_reg_q  <= write_reg_d;
      ex_valid_q   <= ex_valid_d;
      illegal_op_q <= illegal_op_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign RegWrite_ex  = reg_write_q;
  assign ALUSrc_ex    = alu_src_q;
  assign MemWrite_ex  = mem_write_q;
  assign MemRead_ex   = mem_read_q;
  assign MemtoReg_ex  = mem_to_reg_q;
  assign ALUOp_ex     = alu_op_q;
  assign rs_data_ex   = rs_data_q;
  assign rt_data_ex   = rt_data_q;
  assign imm_ext_ex   = imm_ext_q;
  assign rs_addr_ex   = rs_addr_q;
  assign funct_ex     = funct_q;
  assign write_reg_ex = write_reg_q;
  assign ex_valid     = ex_valid_q;
  assign illegal_op   = illegal_op_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid, RegWrite_in, RegDst_in, ALUSrc_in, MemWrite_in, MemRead_in, MemtoReg_in;
  logic [1:0]    ALUOp_in;
  logic [DW-1:0] rs_data_in, rt_data_in, imm_ext_in;
  logic [4:0]    rs_addr_in, rt_addr_in, rd_addr_in;
  logic [5:0]    funct_in;
  logic          flush, ex_ready;
  logic          RegWrite_ex, ALUSrc_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex;
  logic [1:0]    ALUOp_ex;
  logic [DW-1:0] rs_data_ex, rt_data_ex, imm_ext_ex;
  logic [4:0]    rs_addr_ex, write_reg_ex;
  logic [5:0]    funct_ex;
  logic          ex_valid, stall_id, illegal_op;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .RegWrite_in(RegWrite_in), .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in),
    .ALUOp_in(ALUOp_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
    .imm_ext_in(imm_ext_in), .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in),
    .rd_addr_in(rd_addr_in), .funct_in(funct_in), .flush(flush), .ex_ready(ex_ready),
    .RegWrite_ex(RegWrite_ex), .ALUSrc_ex(ALUSrc_ex), .MemWrite_ex(MemWrite_ex),
    .MemRead_ex(MemRead_ex), .MemtoReg_ex(MemtoReg_ex), .ALUOp_ex(ALUOp_ex),
    .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex), .imm_ext_ex(imm_ext_ex),
    .rs_addr_ex(rs_addr_ex), .funct_ex(funct_ex), .write_reg_ex(write_reg_ex),
    .ex_valid(ex_valid), .stall_id(stall_id), .illegal_op(illegal_op),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic          idv, rw, rdst, alusrc, mw, mr, m2r;
    logic [1:0]    op;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] d;
    logic          fl, rdy;
  } in_t;

  typedef struct packed {
    logic          stall, v, rw, mr, mw;
    logic [4:0]    wreg;
    logic [1:0]    op;
    logic [DW-1:0] rsd;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  function automatic in_t mk(logic idv, logic rw, logic rdst, logic alusrc, logic mw, logic mr,
                             logic m2r, logic [1:0] op, logic [4:0] rs, logic [4:0] rt,
                             logic [4:0] rd, logic [DW-1:0] d);
    in_t v;
    v.idv = idv; v.rw = rw; v.rdst = rdst; v.alusrc = alusrc; v.mw = mw; v.mr = mr;
    v.m2r = m2r; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.d = d;
    v.fl = 1'b0; v.rdy = 1'b1;
    return v;
  endfunction

  function automatic in_t addiu(logic [4:0] rs, logic [4:0] rt, logic [DW-1:0] d);
    return mk(1, 1, 0, 1, 0, 0, 0, 2'b00, rs, rt, 5'd9, d);
  endfunction
  function automatic in_t lw(logic [4:0] rs, logic [4:0] rt, logic [DW-1:0] d);
    return mk(1, 1, 0, 1, 0, 1, 1, 2'b00, rs, rt, 5'd0, d);
  endfunction
  function automatic in_t sw(logic [4:0] rs, logic [4:0] rt, logic [DW-1:0] d);
    return mk(1, 0, 0, 1, 1, 0, 0, 2'b00, rs, rt, 5'd0, d);
  endfunction
  function automatic in_t rf(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [DW-1:0] d);
    return mk(1, 1, 1, 0, 0, 0, 0, 2'b10, rs, rt, rd, d);
  endfunction

  function automatic exp_t ex(logic stall, logic v, logic rw, logic mr, logic mw, logic [4:0] wreg,
                              logic [1:0] op, logic [DW-1:0] rsd, logic ill, logic [CW-1:0] cnt);
    exp_t e;
    e.stall = stall; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.wreg = wreg;
    e.op = op; e.rsd = rsd; e.ill = ill; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input in_t v);
    id_valid = v.idv; RegWrite_in = v.rw; RegDst_in = v.rdst; ALUSrc_in = v.alusrc;
    MemWrite_in = v.mw; MemRead_in = v.mr; MemtoReg_in = v.m2r; ALUOp_in = v.op;
    rs_addr_in = v.rs; rt_addr_in = v.rt; rd_addr_in = v.rd; funct_in = {1'b0, v.rd};
    rs_data_in = v.d; rt_data_in = v.d + 1; imm_ext_in = ~v.d;
    flush = v.fl; ex_ready = v.rdy;
  endtask

  // Present one vector for one clock edge and queue what the DUT must show
  task automatic step(input in_t v, input exp_t e);
    apply(v);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"}, DW'(ex_valid), 0);
    chk({tag, " RegWrite_ex"}, DW'(RegWrite_ex), 0);
    chk({tag, " ALUSrc_ex"}, DW'(ALUSrc_ex), 0);
    chk({tag, " MemWrite_ex"}, DW'(MemWrite_ex), 0);
    chk({tag, " MemRead_ex"}, DW'(MemRead_ex), 0);
    chk({tag, " MemtoReg_ex"}, DW'(MemtoReg_ex), 0);
    chk({tag, " ALUOp_ex"}, DW'(ALUOp_ex), 0);
    chk({tag, " rs_data_ex"}, rs_data_ex, 0);
    chk({tag, " rt_data_ex"}, rt_data_ex, 0);
    chk({tag, " imm_ext_ex"}, imm_ext_ex, 0);
    chk({tag, " rs_addr_ex"}, DW'(rs_addr_ex), 0);
    chk({tag, " funct_ex"}, DW'(funct_ex), 0);
    chk({tag, " write_reg_ex"}, DW'(write_reg_ex), 0);
    chk({tag, " illegal_op"}, DW'(illegal_op), 0);
    chk({tag, " bubble_cnt"}, DW'(bubble_cnt), 0);
    chk({tag, " stall_id"}, DW'(stall_id), 0);
  endtask

  // Monitor: stall_id while the vector is presented, registers just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stall_id", DW'(stall_id), DW'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_valid", DW'(ex_valid), DW'(e.v));
        chk("RegWrite_ex", DW'(RegWrite_ex), DW'(e.rw));
        chk("MemRead_ex", DW'(MemRead_ex), DW'(e.mr));
        chk("MemWrite_ex", DW'(MemWrite_ex), DW'(e.mw));
        chk("write_reg_ex", DW'(write_reg_ex), DW'(e.wreg));
        chk("ALUOp_ex", DW'(ALUOp_ex), DW'(e.op));
        chk("rs_data_ex", rs_data_ex, e.rsd);
        chk("rt_data_ex", rt_data_ex, e.rsd + 1);
        chk("imm_ext_ex", imm_ext_ex, ~e.rsd);
        chk("illegal_op", DW'(illegal_op), DW'(e.ill));
        chk("bubble_cnt", DW'(bubble_cnt), DW'(e.cnt));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    in_t nop, v;
    int cb, ca;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, '0);
    apply(nop);
    #3;
    chk_zero("reset");
    apply(addiu(1, 5, 32'hA1));
    @(posedge clk);
    #1;
    chk("reset held across edge ex_valid", DW'(ex_valid), 0);
    #1;
    rst = 1'b0;

    step(addiu(1, 5, 32'hA1), ex(0, 1, 1, 0, 0, 5, 2'b00, 32'hA1, 0, 0));
    step(lw(2, 7, 32'hB2), ex(0, 1, 1, 1, 0, 7, 2'b00, 32'hB2, 0, 0));
    step(rf(7, 8, 10, 32'hC3), ex(1, 0, 0, 0, 0, 7, 2'b00, 32'hB2, 0, 1));
    step(rf(7, 8, 10, 32'hC3), ex(0, 1, 1, 0, 0, 10, 2'b10, 32'hC3, 0, 1));
    step(lw(1, 7, 32'hD4), ex(0, 1, 1, 1, 0, 7, 2'b00, 32'hD4, 0, 1));
    step(addiu(3, 7, 32'hE5), ex(0, 1, 1, 0, 0, 7, 2'b00, 32'hE5, 0, 1));
    step(lw(1, 0, 32'hF6), ex(0, 1, 1, 1, 0, 0, 2'b00, 32'hF6, 0, 1));
    step(rf(0, 0, 11, 32'h17), ex(0, 1, 1, 0, 0, 11, 2'b10, 32'h17, 0, 1));
    step(lw(1, 4, 32'h28), ex(0, 1, 1, 1, 0, 4, 2'b00, 32'h28, 0, 1));
    step(sw(2, 4, 32'h39), ex(1, 0, 0, 0, 0, 4, 2'b00, 32'h28, 0, 2));
    step(sw(2, 4, 32'h39), ex(0, 1, 0, 0, 1, 4, 2'b00, 32'h39, 0, 2));
    step(rf(1, 2, 12, 32'h4A), ex(0, 1, 1, 0, 0, 12, 2'b10, 32'h4A, 0, 2));

    v = addiu(1, 13, 32'h5B);
    v.rdy = 1'b0;
    step(v, ex(1, 1, 1, 0, 0, 12, 2'b10, 32'h4A, 0, 2));
    step(v, ex(1, 1, 1, 0, 0, 12, 2'b10, 32'h4A, 0, 2));
    v.fl = 1'b1;
    step(v, ex(1, 0, 0, 0, 0, 12, 2'b10, 32'h4A, 0, 2));
    v.fl = 1'b0;
    v.rdy = 1'b1;
    step(v, ex(0, 1, 1, 0, 0, 13, 2'b00, 32'h5B, 0, 2));

    step(mk(1, 1, 0, 1, 0, 0, 0, 2'b11, 5'd1, 5'd14, 5'd15, 32'h6C),
         ex(0, 0, 0, 0, 0, 13, 2'b00, 32'h5B, 1, 2));
    step(nop, ex(0, 0, 0, 0, 0, 13, 2'b00, 32'h5B, 0, 2));

    for (int i = 0; i < 14; i++) begin
      cb = (2 + i > 15) ? 15 : 2 + i;
      ca = (3 + i > 15) ? 15 : 3 + i;
      step(lw(1, 7, 32'h70 + i), ex(0, 1, 1, 1, 0, 7, 2'b00, 32'h70 + i, 0, CW'(cb)));
      step(rf(7, 1, 3, 32'hC0), ex(1, 0, 0, 0, 0, 7, 2'b00, 32'h70 + i, 0, CW'(ca)));
    end
    step(addiu(1, 5, 32'h99), ex(0, 1, 1, 0, 0, 5, 2'b00, 32'h99, 0, 4'hF));

    #1;
    rst = 1'b1;
    #1;
    chk_zero("async reset");
    apply(lw(1, 7, 32'h55));
    @(posedge clk);
    #1;
    chk("reset mid-run ex_valid", DW'(ex_valid), 0);
    chk("reset mid-run stall_id", DW'(stall_id), 0);
    #1;
    rst = 1'b0;
    step(addiu(1, 5, 32'hAB), ex(0, 1, 1, 0, 0, 5, 2'b00, 32'hAB, 0, 0));
    @(posedge clk);
    #2;
    chk("scoreboard drained", DW'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
